// File: rtl/ivector_fifo_n_if.sv
// Request/indication handshake bundle for ivector_fifo_n.
// Slave is the FIFO; master is whatever drives requests and sinks indications.
interface ivector_fifo_n_if #(
  parameter int DATA_WIDTH = 192,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 11
);
  localparam int OW = $clog2(DEPTH) + 1;

  logic                  say__ENA;
  logic [DATA_WIDTH-1:0] say_meth;
  logic [DATA_WIDTH-1:0] say_v;
  logic                  say__RDY;
  logic                  flush__ENA;
  logic                  ind_heard__ENA;
  logic [DATA_WIDTH-1:0] ind_heard_meth;
  logic [DATA_WIDTH-1:0] ind_heard_v;
  logic                  ind_heard__RDY;
  logic                  respond_enable;
  logic                  respond_ready;
  logic [OW-1:0]         occupancy;
  logic [CNT_WIDTH-1:0]  heard_count;

  modport slave (
    input  say__ENA, say_meth, say_v, flush__ENA,
    input  ind_heard__RDY, respond_enable,
    output say__RDY, ind_heard__ENA,
    output ind_heard_meth, ind_heard_v,
    output respond_ready, occupancy, heard_count
  );

  modport master (
    output say__ENA, say_meth, say_v, flush__ENA,
    output ind_heard__RDY, respond_enable,
    input  say__RDY, ind_heard__ENA,
    input  ind_heard_meth, ind_heard_v,
    input  respond_ready, occupancy, heard_count
  );
endinterface

// File: rtl/ivector_fifo_n.sv
// DEPTH-entry say->heard indication FIFO with flush,
// occupancy and a wrapping delivered-indication counter.
module ivector_fifo_n #(
  parameter int DATA_WIDTH = 192,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 11
) (
  input  logic           CLK,
  input  logic           RST,
  ivector_fifo_n_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * DATA_WIDTH;

  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [AW:0]          count;
  logic [CNT_WIDTH-1:0] hcnt;
  logic                 full;
  logic                 empty;
  logic                 srdy;
  logic                 rrdy;
  logic                 fire;
  logic                 enq;
  logic                 deq;

  always_comb begin
    full  = (count == (AW+1)'(DEPTH));
    empty = (count == '0);
    srdy  = !RST && !full && !bus.flush__ENA;
    rrdy  = !RST && !empty && bus.ind_heard__RDY
            && !bus.flush__ENA;
    fire  = bus.respond_enable && rrdy;
    enq   = bus.say__ENA && srdy;
    deq   = fire;
  end

  assign bus.say__RDY       = srdy;
  assign bus.respond_ready  = rrdy;
  assign bus.ind_heard__ENA = fire;
  assign bus.ind_heard_meth = mem[rptr][EW-1:DATA_WIDTH];
  assign bus.ind_heard_v    = mem[rptr][DATA_WIDTH-1:0];
  assign bus.occupancy      = count;
  assign bus.heard_count    = hcnt;

  // enq is already gated by RST and flush through srdy
  always_ff @(posedge CLK) begin
    if (enq) begin
      mem[wptr] <= {bus.say_meth, bus.say_v};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      hcnt  <= '0;
    end else if (bus.flush__ENA) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        wptr <= wptr + AW'(1);
      end
      if (deq) begin
        rptr <= rptr + AW'(1);
        hcnt <= hcnt + CNT_WIDTH'(1);
      end
      unique case ({enq, deq})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ivector_fifo_n.sv
// Directed vector bench for ivector_fifo_n (DEPTH=4, CNT_WIDTH=3).
// Each row: inputs held for one cycle, outputs checked mid-cycle.
module tb_ivector_fifo_n;
  localparam int DW = 192;
  localparam int DP = 4;
  localparam int CW = 3;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  ivector_fifo_n_if #(
    .DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)
  ) bus ();

  ivector_fifo_n #(
    .DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  typedef struct {
    bit          rst;
    bit          se;
    bit          fl;
    bit          hr;
    bit          en;
    logic [15:0] m;
    bit          srdy;
    bit          rrdy;
    bit          iena;
    int          occ;
    int          hc;
    bit          ck;
    logic [15:0] hm;
    bit          creg;
  } vec_t;

  vec_t tbl[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void chk(string n, logic [DW-1:0] act,
                              logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endfunction

  function automatic void add(
    bit rst, bit se, bit fl, bit hr, bit en, logic [15:0] m,
    bit srdy, bit rrdy, bit iena, int occ, int hc,
    bit ck, logic [15:0] hm, bit creg);
    vec_t t;
    t.rst = rst; t.se = se; t.fl = fl; t.hr = hr; t.en = en;
    t.m = m; t.srdy = srdy; t.rrdy = rrdy; t.iena = iena;
    t.occ = occ; t.hc = hc; t.ck = ck; t.hm = hm; t.creg = creg;
    tbl.push_back(t);
  endfunction

  task automatic drive(bit rst, bit se, bit fl, bit hr, bit en,
                       logic [15:0] m);
    RST                = rst;
    bus.say__ENA       = se;
    bus.say_meth       = DW'(m);
    bus.say_v          = DW'(m + 16'h11);
    bus.flush__ENA     = fl;
    bus.ind_heard__RDY = hr;
    bus.respond_enable = en;
  endtask

  initial begin
    bit seen;
    total = 0;
    bad   = 0;
    drive(1, 0, 0, 1, 1, 16'h0);

    // reset, single transfer (v = meth + 0x11)
    add(1,0,0,1,1,16'h00, 0,0,0,0,0, 0,16'h00, 0);
    add(1,0,0,1,1,16'h00, 0,0,0,0,0, 0,16'h00, 1);
    add(0,1,0,1,1,16'hA1, 1,0,0,0,0, 0,16'h00, 1);
    add(0,0,0,1,1,16'h00, 1,1,1,1,0, 1,16'hA1, 1);
    add(0,0,0,1,1,16'h00, 1,0,0,0,1, 0,16'h00, 1);
    // fill under backpressure, illegal 5th say
    add(0,1,0,0,1,16'h01, 1,0,0,0,1, 0,16'h00, 1);
    add(0,1,0,0,1,16'h02, 1,0,0,1,1, 1,16'h01, 1);
    add(0,1,0,0,1,16'h03, 1,0,0,2,1, 1,16'h01, 1);
    add(0,1,0,0,1,16'h04, 1,0,0,3,1, 1,16'h01, 1);
    add(0,1,0,0,1,16'h05, 0,0,0,4,1, 1,16'h01, 1);
    add(0,0,0,0,1,16'h00, 0,0,0,4,1, 1,16'h01, 1);
    add(0,0,0,1,1,16'h00, 0,1,1,4,1, 1,16'h01, 1);
    add(0,0,0,1,1,16'h00, 1,1,1,3,2, 1,16'h02, 1);
    add(0,0,0,1,1,16'h00, 1,1,1,2,3, 1,16'h03, 1);
    add(0,0,0,1,1,16'h00, 1,1,1,1,4, 1,16'h04, 1);
    add(0,0,0,1,1,16'h00, 1,0,0,0,5, 0,16'h00, 1);
    // 5..8 across pointer wrap, counter 7 -> 0 -> 1
    add(0,1,0,0,1,16'h05, 1,0,0,0,5, 0,16'h00, 1);
    add(0,1,0,0,1,16'h06, 1,0,0,1,5, 1,16'h05, 1);
    add(0,1,0,0,1,16'h07, 1,0,0,2,5, 1,16'h05, 1);
    add(0,1,0,0,1,16'h08, 1,0,0,3,5, 1,16'h05, 1);
    add(0,0,0,1,1,16'h00, 0,1,1,4,5, 1,16'h05, 1);
    add(0,0,0,1,1,16'h00, 1,1,1,3,6, 1,16'h06, 1);
    add(0,0,0,1,1,16'h00, 1,1,1,2,7, 1,16'h07, 1);
    add(0,0,0,1,1,16'h00, 1,1,1,1,0, 1,16'h08, 1);
    add(0,0,0,1,1,16'h00, 1,0,0,0,1, 0,16'h00, 1);
    // concurrent enq/deq at occupancy 2
    add(0,1,0,0,1,16'h20, 1,0,0,0,1, 0,16'h00, 1);
    add(0,1,0,0,1,16'h21, 1,0,0,1,1, 1,16'h20, 1);
    for (int i = 0; i < 10; i++)
      add(0,1,0,1,1,16'h22 + 16'(i), 1,1,1,2,(1+i)%8,
          1,16'h20 + 16'(i), 1);
    add(0,0,0,0,1,16'h00, 1,0,0,2,3, 1,16'h2A, 1);
    // flush with say and respond requested
    add(0,1,0,0,1,16'h30, 1,0,0,2,3, 1,16'h2A, 1);
    add(0,1,1,1,1,16'h31, 0,0,0,3,3, 1,16'h2A, 1);
    add(0,1,0,0,1,16'h40, 1,0,0,0,3, 0,16'h00, 1);
    add(0,1,0,1,1,16'h50, 1,1,1,1,3, 1,16'h40, 1);
    // reach occupancy 3 / count 5, then reset
    add(0,1,0,0,1,16'h51, 1,0,0,1,4, 1,16'h50, 1);
    add(0,1,0,0,1,16'h52, 1,0,0,2,4, 1,16'h50, 1);
    add(0,1,0,1,1,16'h53, 1,1,1,3,4, 1,16'h50, 1);
    add(0,0,0,0,1,16'h00, 1,0,0,3,5, 1,16'h51, 1);
    add(1,0,0,1,1,16'h00, 0,0,0,0,0, 0,16'h00, 0);
    add(0,0,0,1,1,16'h00, 1,0,0,0,0, 0,16'h00, 1);
    add(0,1,0,1,1,16'h60, 1,0,0,0,0, 0,16'h00, 1);
    add(0,0,0,1,1,16'h00, 1,1,1,1,0, 1,16'h60, 1);
    add(0,0,0,1,1,16'h00, 1,0,0,0,1, 0,16'h00, 1);

    foreach (tbl[i]) begin
      @(negedge CLK);
      drive(tbl[i].rst, tbl[i].se, tbl[i].fl, tbl[i].hr,
            tbl[i].en, tbl[i].m);
      #2;
      chk($sformatf("r%0d say_rdy", i),
          DW'(bus.say__RDY), DW'(tbl[i].srdy));
      chk($sformatf("r%0d resp_rdy", i),
          DW'(bus.respond_ready), DW'(tbl[i].rrdy));
      chk($sformatf("r%0d ind_ena", i),
          DW'(bus.ind_heard__ENA), DW'(tbl[i].iena));
      if (tbl[i].creg) begin
        chk($sformatf("r%0d occ", i),
            DW'(bus.occupancy), DW'(tbl[i].occ));
        chk($sformatf("r%0d hcnt", i),
            DW'(bus.heard_count), DW'(tbl[i].hc));
      end
      if (tbl[i].ck) begin
        chk($sformatf("r%0d meth", i),
            bus.ind_heard_meth, DW'(tbl[i].hm));
        chk($sformatf("r%0d v", i),
            bus.ind_heard_v, DW'(tbl[i].hm + 16'h11));
      end
    end

    // head held under long backpressure, then released
    @(negedge CLK);
    drive(0, 1, 0, 0, 1, 16'h70);
    @(negedge CLK);
    drive(0, 0, 0, 0, 1, 16'h00);
    for (int k = 0; k < 6; k++) begin
      #2;
      chk($sformatf("hold%0d occ", k), DW'(bus.occupancy), DW'(1));
      chk($sformatf("hold%0d ena", k),
          DW'(bus.ind_heard__ENA), DW'(0));
      chk($sformatf("hold%0d meth", k),
          bus.ind_heard_meth, DW'(16'h70));
      @(negedge CLK);
    end
    bus.ind_heard__RDY = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      #2;
      if (bus.ind_heard__ENA) begin
        seen = 1'b1;
        chk("release meth", bus.ind_heard_meth, DW'(16'h70));
      end
      @(negedge CLK);
    end
    chk("release seen", DW'(seen), DW'(1));
    #2;
    chk("release occ", DW'(bus.occupancy), DW'(0));
    chk("release hcnt", DW'(bus.heard_count), DW'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
